// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional hazard statistics counters are enabled by defining ID_EX_HAZARD_STATS_EN.
module id_ex_stage #(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 3,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [3:0]         id_mem_sig,
   input  logic [5:0]         id_ex_sig,
   input  logic [2:0]         id_wb_sig,
   input  logic [DATA_W-1:0]  id_src_data,
   input  logic [DATA_W-1:0]  id_dst_data,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic [RADDR_W-1:0] id_src_addr,
   input  logic [RADDR_W-1:0] id_dst_addr,
   input  logic               id_uses_src,
   input  logic               id_uses_dst,
   input  logic               flush,
   input  logic               ex_stall,
   output logic               id_hold,
   output logic               ex_valid,
   output logic [3:0]         ex_mem_sig,
   output logic [5:0]         ex_ex_sig,
   output logic [2:0]         ex_wb_sig,
   output logic [DATA_W-1:0]  ex_src_data,
   output logic [DATA_W-1:0]  ex_dst_data,
   output logic [DATA_W-1:0]  ex_imm,
   output logic [RADDR_W-1:0] ex_src_addr,
   output logic [RADDR_W-1:0] ex_dst_addr,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   stall_cnt
);

   // A bubble writes back with WBsel=11 and regWrite=0, so it is a harmless NOP downstream.
   localparam logic [2:0] BUBBLE_WB = 3'b011;

   logic lu_hazard;
   logic src_match;
   logic dst_match;
   logic load_bubble;

   assign src_match = id_uses_src && (id_src_addr == ex_dst_addr);
   assign dst_match = id_uses_dst && (id_dst_addr == ex_dst_addr);

   // Only a load that writes a register can starve its consumer of data.
   assign lu_hazard = id_valid && ex_valid && ex_mem_sig[3] && ex_wb_sig[2]
                      && (src_match || dst_match);

   // Handshake: ex_stall holds everything (flush included); id_hold freezes decode so the
   // same instruction re-presents next cycle, and any flush must be re-asserted by its source.
   assign id_hold = ex_stall || (lu_hazard && !flush);

   assign load_bubble = flush || lu_hazard || !id_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_mem_sig  <= 4'b0000;
         ex_ex_sig   <= 6'b000000;
         ex_wb_sig   <= BUBBLE_WB;
         ex_src_data <= '0;
         ex_dst_data <= '0;
         ex_imm      <= '0;
         ex_src_addr <= '0;
         ex_dst_addr <= '0;
      end else if (!ex_stall) begin
         if (load_bubble) begin
            ex_valid    <= 1'b0;
            ex_mem_sig  <= 4'b0000;
            ex_ex_sig   <= 6'b000000;
            ex_wb_sig   <= BUBBLE_WB;
            ex_src_data <= '0;
            ex_dst_data <= '0;
            ex_imm      <= '0;
            ex_src_addr <= '0;
            ex_dst_addr <= '0;
         end else begin
            ex_valid    <= 1'b1;
            ex_mem_sig  <= id_mem_sig;
            ex_ex_sig   <= id_ex_sig;
            ex_wb_sig   <= id_wb_sig;
            ex_src_data <= id_src_data;
            ex_dst_data <= id_dst_data;
            ex_imm      <= id_imm;
            ex_src_addr <= id_src_addr;
            ex_dst_addr <= id_dst_addr;
         end
      end
   end

`ifdef ID_EX_HAZARD_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Saturating counters; a bubble counts only when the hazard actually wins priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (ex_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_ONE;
         if (!ex_stall && !flush && lu_hazard && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + CNT_ONE;
      end
   end
`else
   assign bubble_cnt = '0;
   assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, pass-through, load-use bubble, stall/flush, saturation.
// Counter expectations follow ID_EX_HAZARD_STATS_EN (zero when undefined).
module tb_id_ex_stage;

   localparam int DATA_W  = 16;
   localparam int RADDR_W = 3;
   localparam int CNT_W   = 16;

`ifdef ID_EX_HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic               clk;
   logic               rst_n;
   logic               id_valid;
   logic [3:0]         id_mem_sig;
   logic [5:0]         id_ex_sig;
   logic [2:0]         id_wb_sig;
   logic [DATA_W-1:0]  id_src_data;
   logic [DATA_W-1:0]  id_dst_data;
   logic [DATA_W-1:0]  id_imm;
   logic [RADDR_W-1:0] id_src_addr;
   logic [RADDR_W-1:0] id_dst_addr;
   logic               id_uses_src;
   logic               id_uses_dst;
   logic               flush;
   logic               ex_stall;
   logic               id_hold;
   logic               ex_valid;
   logic [3:0]         ex_mem_sig;
   logic [5:0]         ex_ex_sig;
   logic [2:0]         ex_wb_sig;
   logic [DATA_W-1:0]  ex_src_data;
   logic [DATA_W-1:0]  ex_dst_data;
   logic [DATA_W-1:0]  ex_imm;
   logic [RADDR_W-1:0] ex_src_addr;
   logic [RADDR_W-1:0] ex_dst_addr;
   logic [CNT_W-1:0]   bubble_cnt;
   logic [CNT_W-1:0]   stall_cnt;

   // Narrow-counter instance shares all inputs; only its counters are observed.
   logic               s_id_hold;
   logic               s_ex_valid;
   logic [3:0]         s_ex_mem_sig;
   logic [5:0]         s_ex_ex_sig;
   logic [2:0]         s_ex_wb_sig;
   logic [DATA_W-1:0]  s_ex_src_data;
   logic [DATA_W-1:0]  s_ex_dst_data;
   logic [DATA_W-1:0]  s_ex_imm;
   logic [RADDR_W-1:0] s_ex_src_addr;
   logic [RADDR_W-1:0] s_ex_dst_addr;
   logic [1:0]         s_bubble_cnt;
   logic [1:0]         s_stall_cnt;

   int total_checks;
   int passed_checks;

   id_ex_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_mem_sig(id_mem_sig),
      .id_ex_sig(id_ex_sig), .id_wb_sig(id_wb_sig), .id_src_data(id_src_data),
      .id_dst_data(id_dst_data), .id_imm(id_imm), .id_src_addr(id_src_addr),
      .id_dst_addr(id_dst_addr), .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst),
      .flush(flush), .ex_stall(ex_stall), .id_hold(id_hold), .ex_valid(ex_valid),
      .ex_mem_sig(ex_mem_sig), .ex_ex_sig(ex_ex_sig), .ex_wb_sig(ex_wb_sig),
      .ex_src_data(ex_src_data), .ex_dst_data(ex_dst_data), .ex_imm(ex_imm),
      .ex_src_addr(ex_src_addr), .ex_dst_addr(ex_dst_addr),
      .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
   );

   id_ex_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_mem_sig(id_mem_sig),
      .id_ex_sig(id_ex_sig), .id_wb_sig(id_wb_sig), .id_src_data(id_src_data),
      .id_dst_data(id_dst_data), .id_imm(id_imm), .id_src_addr(id_src_addr),
      .id_dst_addr(id_dst_addr), .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst),
      .flush(flush), .ex_stall(ex_stall), .id_hold(s_id_hold), .ex_valid(s_ex_valid),
      .ex_mem_sig(s_ex_mem_sig), .ex_ex_sig(s_ex_ex_sig), .ex_wb_sig(s_ex_wb_sig),
      .ex_src_data(s_ex_src_data), .ex_dst_data(s_ex_dst_data), .ex_imm(s_ex_imm),
      .ex_src_addr(s_ex_src_addr), .ex_dst_addr(s_ex_dst_addr),
      .bubble_cnt(s_bubble_cnt), .stall_cnt(s_stall_cnt)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_checks++;
      assert (obs === exp) passed_checks++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      id_valid    = 1'b0;
      id_mem_sig  = 4'b0000;
      id_ex_sig   = 6'b000000;
      id_wb_sig   = 3'b011;
      id_src_data = '0;
      id_dst_data = '0;
      id_imm      = '0;
      id_src_addr = '0;
      id_dst_addr = '0;
      id_uses_src = 1'b0;
      id_uses_dst = 1'b0;
      flush       = 1'b0;
      ex_stall    = 1'b0;
   endtask

   task automatic drive(input logic [3:0] mem, input logic [5:0] ex, input logic [2:0] wb,
                        input logic [15:0] src, input logic [15:0] dst, input logic [15:0] imm,
                        input logic [2:0] sa, input logic [2:0] da,
                        input logic us, input logic ud);
      id_valid    = 1'b1;
      id_mem_sig  = mem;
      id_ex_sig   = ex;
      id_wb_sig   = wb;
      id_src_data = src;
      id_dst_data = dst;
      id_imm      = imm;
      id_src_addr = sa;
      id_dst_addr = da;
      id_uses_src = us;
      id_uses_dst = ud;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, ".valid"}, {31'd0, ex_valid}, 32'd0);
      check({tag, ".mem"}, {28'd0, ex_mem_sig}, 32'h0);
      check({tag, ".ex"}, {26'd0, ex_ex_sig}, 32'h0);
      check({tag, ".wb"}, {29'd0, ex_wb_sig}, 32'h3);
      check({tag, ".data"}, {ex_src_data, ex_dst_data}, 32'h0);
      check({tag, ".imm_addr"}, {10'd0, ex_imm, ex_src_addr, ex_dst_addr}, 32'h0);
   endtask

   initial begin
      total_checks  = 0;
      passed_checks = 0;
      set_idle();
      rst_n = 1'b0;
      #12;
      check_bubble("reset");
      check("reset.hold", {31'd0, id_hold}, 32'd0);
      check("reset.bcnt", {16'd0, bubble_cnt}, 32'd0);
      rst_n = 1'b1;
      tick();
      check_bubble("idle_after_reset");

      // Pass-through ADD
      drive(4'b0000, 6'b001010, 3'b101, 16'h1234, 16'h00ab, 16'h0055, 3'd1, 3'd2, 1'b1, 1'b1);
      #1;
      check("add.hold", {31'd0, id_hold}, 32'd0);
      tick();
      set_idle();
      check("add.valid", {31'd0, ex_valid}, 32'd1);
      check("add.sigs", {19'd0, ex_mem_sig, ex_ex_sig, ex_wb_sig}, {19'd0, 4'b0000, 6'b001010, 3'b101});
      check("add.src", {16'd0, ex_src_data}, 32'h1234);
      check("add.dst_imm", {ex_dst_data, ex_imm}, 32'h00ab_0055);
      check("add.addr", {26'd0, ex_src_addr, ex_dst_addr}, {26'd0, 3'd1, 3'd2});
      tick();
      check_bubble("idle");

      // Load to R3 then dependent reader of R3
      drive(4'b1000, 6'b000010, 3'b100, 16'h0010, 16'h0000, 16'h0004, 3'd1, 3'd3, 1'b1, 1'b0);
      tick();
      check("ldd.valid", {31'd0, ex_valid}, 32'd1);
      drive(4'b0000, 6'b001010, 3'b101, 16'h0777, 16'h0888, 16'h0000, 3'd3, 3'd5, 1'b1, 1'b1);
      #1;
      check("lu.hold", {31'd0, id_hold}, 32'd1);
      tick();
      check("lu.bubble_valid", {31'd0, ex_valid}, 32'd0);
      check("lu.bubble_wb", {29'd0, ex_wb_sig}, 32'h3);
      check("lu.hold_cleared", {31'd0, id_hold}, 32'd0);
      check("lu.bcnt", {16'd0, bubble_cnt}, STATS ? 32'd1 : 32'd0);
      tick();
      check("dep.valid", {31'd0, ex_valid}, 32'd1);
      check("dep.src", {ex_src_data, 13'd0, ex_src_addr}, {16'h0777, 13'd0, 3'd3});

      // Store in EX must not cause a hazard
      drive(4'b0110, 6'b000010, 3'b000, 16'h0000, 16'h0999, 16'h0000, 3'd1, 3'd4, 1'b1, 1'b1);
      tick();
      drive(4'b0000, 6'b001100, 3'b101, 16'h0abc, 16'h0000, 16'h0000, 3'd4, 3'd6, 1'b1, 1'b0);
      #1;
      check("std.hold", {31'd0, id_hold}, 32'd0);
      tick();
      check("std.dep_valid", {31'd0, ex_valid}, 32'd1);
      check("std.dep_src", {ex_src_data, 13'd0, ex_src_addr}, {16'h0abc, 13'd0, 3'd4});

      // Stall with flush for three cycles holds the register
      drive(4'b0000, 6'b000001, 3'b101, 16'h5555, 16'h6666, 16'h7777, 3'd7, 3'd7, 1'b1, 1'b1);
      ex_stall = 1'b1;
      flush    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall.hold", {31'd0, id_hold}, 32'd1);
         tick();
         check("stall.kept", {ex_src_data, 13'd0, ex_src_addr}, {16'h0abc, 13'd0, 3'd4});
         check("stall.valid", {31'd0, ex_valid}, 32'd1);
      end
      check("stall.scnt", {16'd0, stall_cnt}, STATS ? 32'd3 : 32'd0);
      ex_stall = 1'b0;
      #1;
      check("flush.hold", {31'd0, id_hold}, 32'd0);
      tick();
      check_bubble("flush");
      check("flush.bcnt", {16'd0, bubble_cnt}, STATS ? 32'd1 : 32'd0);

      // Asynchronous reset mid-cycle with a valid instruction in the register
      set_idle();
      drive(4'b0000, 6'b001010, 3'b101, 16'h4321, 16'h0000, 16'h0000, 3'd2, 3'd1, 1'b1, 1'b0);
      tick();
      check("prerst.valid", {31'd0, ex_valid}, 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check_bubble("async_reset");
      check("async_reset.cnts", {bubble_cnt, stall_cnt}, 32'd0);
      set_idle();
      #2;
      rst_n = 1'b1;
      tick();
      check_bubble("post_reset");
      check("post_reset.hold", {31'd0, id_hold}, 32'd0);

      // Five load-use pairs: wide counter reaches 5, 2-bit counter saturates at 3
      for (int n = 0; n < 5; n++) begin
         drive(4'b1000, 6'b000010, 3'b100, 16'h0000, 16'h0000, 16'h0002, 3'd0, 3'd2, 1'b1, 1'b0);
         tick();
         drive(4'b0000, 6'b001010, 3'b101, 16'h0000, 16'h0000, 16'h0000, 3'd0, 3'd2, 1'b0, 1'b1);
         #1;
         check("sat.hold", {31'd0, id_hold}, 32'd1);
         tick();
         tick();
         check("sat.dep_valid", {31'd0, ex_valid}, 32'd1);
      end
      set_idle();
      tick();
      check("sat.bcnt_wide", {16'd0, bubble_cnt}, STATS ? 32'd5 : 32'd0);
      check("sat.bcnt_narrow", {30'd0, s_bubble_cnt}, STATS ? 32'd3 : 32'd0);
      check("sat.scnt_narrow", {30'd0, s_stall_cnt}, 32'd0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode/execute pipeline register. It captures the decode control bundles (MEM 4b, EX 6b, WB 3b), operands and register addresses. It presents them to the execute stage one cycle later. It also owns load-use hazard detection: it inserts a one-cycle bubble and holds fetch/decode while a load's destination is still in flight.

Parameters:
DATA_W, 16, operand/immediate width
RADDR_W, 3, register-file address width
CNT_W, 16, width of hazard statistics counters (optional feature only)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode holds a real instruction
id_mem_sig  in  4  {memRead, memWrite, memAddress, memData}
id_ex_sig  in  6  {ALUop[3:0], ALU_en, shamSel}
id_wb_sig  in  3  {regWrite, WBsel[1:0]}
id_src_data  in  DATA_W  Rsrc read data
id_dst_data  in  DATA_W  Rdst read data
id_imm  in  DATA_W  immediate
id_src_addr  in  RADDR_W  Rsrc index
id_dst_addr  in  RADDR_W  Rdst index
id_uses_src  in  1  instruction reads Rsrc
id_uses_dst  in  1  instruction reads Rdst
flush  in  1  kill the instruction entering from decode
ex_stall  in  1  downstream cannot accept; hold register
id_hold  out  1  freeze PC and IF/ID this cycle
ex_valid  out  1  register holds a real instruction
ex_mem_sig  out  4  registered MEM bundle
ex_ex_sig  out  6  registered EX bundle
ex_wb_sig  out  3  registered WB bundle
ex_src_data, ex_dst_data, ex_imm  out  DATA_W  registered operands
ex_src_addr, ex_dst_addr  out  RADDR_W  registered indices
bubble_cnt  out  CNT_W  load-use bubbles inserted (optional)
stall_cnt  out  CNT_W  ex_stall cycles (optional)

Behaviour:
- Bubble value: valid=0, mem_sig=4'b0000, ex_sig=6'b000000, wb_sig=3'b011, data/addr=0. It is fully defined, with no x/z.
- Reset (rst_n=0, asynchronous): all ex_* outputs take the bubble value. Counters = 0. The id_hold output follows its combinational equation.
- Hazard: lu_hazard = id_valid & ex_valid & ex_mem_sig[3] & ex_wb_sig[2] & ((id_uses_src & id_src_addr==ex_dst_addr) | (id_uses_dst & id_dst_addr==ex_dst_addr)). It is combinational from current register contents and decode inputs.
- id_hold = ex_stall | (lu_hazard & ~flush). It is combinational with zero latency.
- Per rising edge, strict priority:
  1. ex_stall=1: hold every register unchanged, flush included. Decode holds too, so the flush request must be re-asserted.
  2. flush=1: load the bubble.
  3. lu_hazard=1: load the bubble. Decode is held, so the same instruction re-presents next cycle. The load has then advanced and the register holds a bubble (ex_valid=0), so the hazard clears. Exactly one bubble is inserted per load-use pair.
  4. id_valid=0: load the bubble.
  5. Otherwise: load all id_* inputs and set ex_valid=1.
- Latency: a decode instruction appears on ex_* one cycle after the edge where it is accepted (case 5).
- A store (memWrite, regWrite=0) in EX never triggers a hazard. A NOP (WB=011) never triggers one. An instruction not using a register (uses_*=0) never triggers one.
- Back-to-back loads with a dependent chain: each dependent instruction gets its own single bubble.
- Reset mid-stall or mid-bubble: the register returns to the bubble value immediately. No residual hold after rst_n deasserts unless inputs demand it.

Optional Feature:
Macro ID_EX_HAZARD_STATS_EN.
- Defined: bubble_cnt increments on each edge taking case 3. stall_cnt increments on each edge with ex_stall=1. Both saturate at all-ones and never wrap. Both are cleared only by reset.
- Undefined: both ports are driven constant 0 and no counter flops are inferred. The port list is unchanged.

Test Plan:
- Reset: rst_n=0 mid-cycle with ex_valid=1 -> all outputs immediately take the bubble value, wb=011 and valid=0. After release with id_valid=0 they stay bubble.
- Pass-through: ADD with ex_sig=6'b001010, wb=101, src=0x1234, id_valid=1 -> the next cycle shows identical ex_* fields, ex_valid=1 and id_hold=0.
- Load-use: LDD to R3 (mem=1000, wb=100) followed by an instruction with uses_src=1 and src_addr=3 -> id_hold=1 for one cycle and a bubble is inserted. The dependent instruction appears on ex_* one cycle later. bubble_cnt=1.
- No false hazard: STD in EX (mem=0110, wb=0xx) with dependent src_addr matching -> id_hold=0 and no bubble.
- Stall vs flush: ex_stall=1 with flush=1 for 3 cycles -> the register is unchanged and id_hold=1 throughout. stall_cnt=3. When the stall drops with flush=1, a bubble is loaded.
- Saturation (macro on, CNT_W=2): 5 load-use bubbles -> bubble_cnt reads 3 and stays 3.
